keypad_item_encoder: RTL and testbench

//   Scans a 4x4 active-low matrix keypad and debounces it. Each accepted key press

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_item_encoder_code_map.sv | 24 ++
 rtl/keypad_item_encoder.sv | 155 +++++++++++++++
 tb/tb_keypad_item_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad item encoder: FSM states, key codes and
// the single-row decode helpers used by the scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StReport,
    StRelease
  } state_e;

  localparam logic [7:0] CODE_ITEM1           = 8'h01;
  localparam logic [7:0] CODE_ITEM2           = 8'h02;
  localparam logic [7:0] CODE_ITEM3           = 8'h03;
  localparam logic [7:0] CODE_ITEM4           = 8'h04;
  localparam logic [7:0] CODE_CLEAR           = 8'hFF;
  localparam logic [7:0] CODE_UNASSIGNED_BASE = 8'h80;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // True when exactly one active-low row is asserted.
  function automatic logic single_low(input logic [3:0] rows);
    return rows inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    case (rows)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_item_encoder_code_map.sv
// Combinational key-position to item-code table; the only place key codes are assigned.
module keypad_code_map
  import keypad_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  output logic [7:0] code_o
);

  logic [3:0] key;

  always_comb begin
    key = {row_i, col_i};
    unique case (key)
      4'd0:    code_o = CODE_ITEM1;
      4'd1:    code_o = CODE_ITEM2;
      4'd2:    code_o = CODE_ITEM3;
      4'd3:    code_o = CODE_ITEM4;
      4'd15:   code_o = CODE_CLEAR;
      default: code_o = CODE_UNASSIGNED_BASE | {4'h0, key};
    endcase
  end

endmodule

// File: rtl/keypad_item_encoder.sv
// 4x4 active-low keypad scanner/debouncer emitting one flag strobe per accepted press.
// Optional auto-repeat while a key is held is enabled with KEYPAD_AUTO_REPEAT_EN.
module keypad_item_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned REPEAT_CYC   = 25000000
) (
  input  logic       clock,
  input  logic       clr,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       flag,
  output logic [7:0] correspond
);

  localparam int unsigned SW = $clog2(SCAN_DIV + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CYC < 1 || REPEAT_CYC < 1) begin : g_param_check
    $error("keypad_item_encoder: SCAN_DIV must be >= 4 and cycle counts non-zero");
  end

  state_e        state_q, state_d;
  logic [3:0]    rs_meta_q, rs_q;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    row_q, row_d;
  logic [7:0]    correspond_q;
  logic [7:0]    key_code;
  logic          rep_fire;

  keypad_code_map u_code_map (
    .row_i  (row_q),
    .col_i  (col_idx_q),
    .code_o (key_code)
  );

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYC + 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  assign rep_fire = (state_q == StRelease) && (rs_q == pat_q) &&
                    (rep_cnt_q == RW'(REPEAT_CYC - 1));

  // Counts held-stable cycles; restarts after each repeat and on any glitch.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (state_q != StRelease || rs_q != pat_q || rep_fire) begin
      rep_cnt_d = '0;
    end else begin
      rep_cnt_d = rep_cnt_q + RW'(1);
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q      <= StScan;
      rs_meta_q    <= 4'hF;
      rs_q         <= 4'hF;
      col_idx_q    <= '0;
      scan_cnt_q   <= '0;
      deb_cnt_q    <= '0;
      pat_q        <= 4'hF;
      row_q        <= '0;
      correspond_q <= '0;
    end else begin
      state_q    <= state_d;
      rs_meta_q  <= row_in;
      rs_q       <= rs_meta_q;
      col_idx_q  <= col_idx_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      pat_q      <= pat_d;
      row_q      <= row_d;
      if (state_q == StDebounce && state_d == StReport) begin
        correspond_q <= key_code;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    pat_d      = pat_q;
    row_d      = row_q;
    unique case (state_q)
      StScan: begin
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
          scan_cnt_d = '0;
          if (single_low(rs_q)) begin
            state_d   = StDebounce;
            pat_d     = rs_q;
            row_d     = low_row(rs_q);
            deb_cnt_d = '0;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      StDebounce: begin
        if (rs_q != pat_q) begin
          state_d    = StScan;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else if (deb_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
          state_d = StReport;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      StReport: begin
        state_d   = StRelease;
        deb_cnt_d = '0;
      end
      StRelease: begin
        if (rs_q != 4'hF) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
          state_d    = StScan;
          col_idx_d  = '0;
          scan_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_comb begin
    col_out    = ~(~COL_RESET << col_idx_q);
    flag       = (state_q == StReport) || rep_fire;
    correspond = correspond_q;
  end

endmodule

// File: tb/tb_keypad_item_encoder.sv
// Directed, table-driven bench for keypad_item_encoder with a matrix keypad model.
// Repeat expectations follow KEYPAD_AUTO_REPEAT_EN.
module tb_keypad_item_encoder;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CYC = 8;
  localparam int unsigned REPEAT_CYC   = 50;
  localparam int          MAX_LAT      = 4 * SCAN_DIV + 2 + DEBOUNCE_CYC + 1;
`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int          HOLD_LONG    = 40;
`else
  localparam int          HOLD_LONG    = 100;
`endif

  logic       clock = 1'b0;
  logic       clr;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       flag;
  logic [7:0] correspond;

  logic [15:0] keys = '0;
  int          cyc = 0;
  int          flag_cnt = 0;
  logic [7:0]  last_code = '0;
  int          flag_cyc[$];
  int          checks = 0;
  int          failures = 0;

  keypad_item_encoder #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) dut (
    .clock      (clock),
    .clr        (clr),
    .row_in     (row_in),
    .col_out    (col_out),
    .flag       (flag),
    .correspond (correspond)
  );

  always #5 clock = ~clock;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (flag) begin
      flag_cnt++;
      last_code = correspond;
      flag_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  typedef struct {
    int         k;
    logic [7:0] code;
    int         hold;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int         base;
    int         lat;
    logic [3:0] held;
    int         waited;
    base = flag_cnt;
    lat  = 0;
    keys = 16'(1) << v.k;
    while (flag_cnt == base && lat <= MAX_LAT) begin
      tick(1);
      lat++;
    end
    check($sformatf("latency k=%0d", v.k), 32'(lat <= MAX_LAT), 32'd1);
    check($sformatf("code k=%0d", v.k), 32'(last_code), 32'(v.code));
    if (v.hold > lat) tick(v.hold - lat);
    held   = col_out;
    keys   = '0;
    waited = 0;
    while (col_out == held && waited < 40) begin
      tick(1);
      waited++;
    end
    if (v.k % 4 != 0) check($sformatf("rescan col k=%0d", v.k), 32'(col_out), 32'h0000000E);
    tick(20);
    check($sformatf("one flag k=%0d", v.k), 32'(flag_cnt - base), 32'd1);
  endtask

  initial begin
    int base;
    int first;
    int lat;

    clr = 1'b1;
    #1;
    check("reset col_out", 32'(col_out), 32'h0000000E);
    check("reset flag", 32'(flag), 32'd0);
    check("reset correspond", 32'(correspond), 32'd0);
    tick(3);
    clr = 1'b0;
    tick(5);

    vecs[0] = '{k: 1,  code: 8'h02, hold: HOLD_LONG};
    vecs[1] = '{k: 15, code: 8'hFF, hold: 40};
    vecs[2] = '{k: 6,  code: 8'h86, hold: 40};
    vecs[3] = '{k: 0,  code: 8'h01, hold: 40};
    vecs[4] = '{k: 3,  code: 8'h04, hold: 40};
    vecs[5] = '{k: 9,  code: 8'h89, hold: 40};
    vecs[6] = '{k: 12, code: 8'h8C, hold: 40};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Bouncing key never stays stable long enough.
    base = flag_cnt;
    for (int i = 0; i < 20; i++) begin
      keys[0] = ~keys[0];
      tick(3);
    end
    keys = '0;
    tick(40);
    check("bounce no flag", 32'(flag_cnt - base), 32'd0);

    // Two rows low in the same column is ambiguous.
    base = flag_cnt;
    keys = (16'(1) << 2) | (16'(1) << 6);
    tick(60);
    keys = '0;
    tick(30);
    check("two rows no flag", 32'(flag_cnt - base), 32'd0);

    // Second key in another column is ignored while the first is held.
    base = flag_cnt;
    lat  = 0;
    keys = 16'(1) << 1;
    while (flag_cnt == base && lat <= MAX_LAT) begin
      tick(1);
      lat++;
    end
    keys = keys | (16'(1) << 8);
    tick(40);
    keys = '0;
    tick(40);
    check("two keys one flag", 32'(flag_cnt - base), 32'd1);
    check("two keys code", 32'(last_code), 32'h02);

    // Hold k=2 for 130 cycles past its first flag.
    base = flag_cnt;
    lat  = 0;
    keys = 16'(1) << 2;
    while (flag_cnt == base && lat <= MAX_LAT) begin
      tick(1);
      lat++;
    end
    check("hold latency", 32'(lat <= MAX_LAT), 32'd1);
    tick(130);
    keys = '0;
    tick(40);
    check("hold code", 32'(last_code), 32'h03);
`ifdef KEYPAD_AUTO_REPEAT_EN
    check("repeat count", 32'(flag_cnt - base), 32'd3);
    if (flag_cyc.size() >= base + 3) begin
      first = flag_cyc[base];
      check("repeat 1 spacing", 32'(flag_cyc[base+1] - first), 32'd50);
      check("repeat 2 spacing", 32'(flag_cyc[base+2] - first), 32'd100);
    end
`else
    check("no repeat count", 32'(flag_cnt - base), 32'd1);
`endif

    // Asynchronous reset mid-press aborts without a later flag.
    keys = 16'(1) << 5;
    tick(20);
    #1;
    clr = 1'b1;
    base = flag_cnt;
    #1;
    check("async col_out", 32'(col_out), 32'h0000000E);
    check("async flag", 32'(flag), 32'd0);
    check("async correspond", 32'(correspond), 32'd0);
    tick(2);
    keys = '0;
    tick(1);
    clr = 1'b0;
    tick(60);
    check("no flag after reset", 32'(flag_cnt - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
